// File: rtl/upsample_unit.sv
// 2x nearest-neighbour pixel upsampler with a one-row line buffer and a
// zero-latency bypass mode selected at row-pair boundaries.
module upsample_unit #(
    parameter int unsigned IN_WIDTH = 56
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable_upsample,
    input  logic       valid_in,
    input  logic [7:0] data_in,
    output logic       ready_in,
    output logic       valid_out,
    output logic [7:0] data_out,
    input  logic       ready_out
);

    localparam int unsigned CW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(IN_WIDTH - 1);

    typedef enum logic {
        FILL,
        REPLAY
    } state_t;

    state_t        state;
    logic          mode_q;
    logic          dup;
    logic          out_vld;
    logic [7:0]    out_data;
    logic [CW-1:0] wr_col;
    logic [CW-1:0] rd_col;
    logic [7:0]    line_buf [IN_WIDTH];

    logic idle;
    logic fill_rdy;
    logic in_hs;
    logic out_hs;

    // Handshake qualifiers and the mode-dependent output mux.
    always_comb begin
        idle     = (state == FILL) && (wr_col == '0) && (rd_col == '0) && !out_vld;
        fill_rdy = !out_vld || (ready_out && dup && (rd_col != LAST));

        ready_in  = ready_out;
        valid_out = valid_in;
        data_out  = data_in;
        if (mode_q) begin
            if (state == REPLAY) begin
                ready_in  = 1'b0;
                valid_out = 1'b1;
                data_out  = line_buf[rd_col];
            end else begin
                ready_in  = fill_rdy;
                valid_out = out_vld;
                data_out  = out_data;
            end
        end

        in_hs  = mode_q && (state == FILL) && valid_in && fill_rdy;
        out_hs = mode_q && valid_out && ready_out;
    end

    // Control state; an input accept overrides the out_vld clear of the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= FILL;
            mode_q   <= 1'b0;
            dup      <= 1'b0;
            out_vld  <= 1'b0;
            out_data <= 8'h00;
            wr_col   <= '0;
            rd_col   <= '0;
        end else begin
            if (idle) begin
                mode_q <= enable_upsample;
            end
            if (state == FILL) begin
                if (out_hs) begin
                    if (!dup) begin
                        dup <= 1'b1;
                    end else if (rd_col == LAST) begin
                        state   <= REPLAY;
                        rd_col  <= '0;
                        wr_col  <= '0;
                        out_vld <= 1'b0;
                        dup     <= 1'b0;
                    end else begin
                        rd_col  <= rd_col + 1'b1;
                        out_vld <= 1'b0;
                    end
                end
                if (in_hs) begin
                    out_data <= data_in;
                    out_vld  <= 1'b1;
                    dup      <= 1'b0;
                    wr_col   <= wr_col + 1'b1;
                end
            end else if (out_hs) begin
                dup <= !dup;
                if (dup) begin
                    if (rd_col == LAST) begin
                        state  <= FILL;
                        rd_col <= '0;
                    end else begin
                        rd_col <= rd_col + 1'b1;
                    end
                end
            end
        end
    end

    // Line buffer is never reset; replay only reads columns written this row.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            line_buf[wr_col] <= data_in;
        end
    end

endmodule

// File: tb/tb_upsample_unit.sv
// Randomized scoreboard bench for upsample_unit with a row-level reference model.
module tb_upsample_unit;

    localparam int unsigned W = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable_upsample;
    logic       valid_in;
    logic [7:0] data_in;
    logic       ready_in;
    logic       valid_out;
    logic [7:0] data_out;
    logic       ready_out;

    always #5 clk = ~clk;

    upsample_unit #(.IN_WIDTH(W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable_upsample(enable_upsample),
        .valid_in       (valid_in),
        .data_in        (data_in),
        .ready_in       (ready_in),
        .valid_out      (valid_out),
        .data_out       (data_out),
        .ready_out      (ready_out)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] stim_q[$];
    logic [7:0] row_buf[$];
    bit         mdl_up  = 1'b0;
    int         out_cnt = 0;
    bit         stall_p = 1'b0;
    logic [7:0] stall_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a row of W pixels becomes [p0 p0 p1 p1 ...] emitted twice; bypass is identity.
    function automatic void accept(input logic [7:0] px);
        if (!mdl_up) begin
            exp_q.push_back(px);
        end else begin
            exp_q.push_back(px);
            exp_q.push_back(px);
            row_buf.push_back(px);
            if (row_buf.size() == W) begin
                foreach (row_buf[i]) begin
                    exp_q.push_back(row_buf[i]);
                    exp_q.push_back(row_buf[i]);
                end
                row_buf.delete();
            end
        end
    endfunction

    // Monitor: pops the scoreboard on every output transfer and checks protocol properties.
    always @(negedge clk) begin
        logic [7:0] e;
        #1;
        if (!reset_n) begin
            stall_p = 1'b0;
            out_cnt = 0;
        end else begin
            if (stall_p) begin
                check("stall_valid", 32'(valid_out), 32'd1);
                check("stall_data", 32'(data_out), 32'(stall_d));
            end
            if (!mdl_up) begin
                check("byp_valid", 32'(valid_out), 32'(valid_in));
                check("byp_ready", 32'(ready_in), 32'(ready_out));
                if (valid_in) check("byp_data", 32'(data_out), 32'(data_in));
            end else if ((out_cnt % (4 * W)) >= (2 * W)) begin
                check("replay_ready_in", 32'(ready_in), 32'd0);
                check("replay_valid", 32'(valid_out), 32'd1);
            end
            if (valid_out && ready_out) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0h expected none", data_out);
                end else begin
                    e = exp_q.pop_front();
                    check("data_out", 32'(data_out), 32'(e));
                end
                if (mdl_up) out_cnt++;
            end
            stall_p = valid_out && !ready_out;
            stall_d = data_out;
        end
    end

    // Streams stim_q; rmode 0=ready high, 1=toggle, 2=random. Stops after max_acc accepts.
    task automatic run(input int rmode, input int vprob, input int max_acc);
        int cyc = 0;
        int acc = 0;
        bit hold = 1'b0;
        while (acc < max_acc && (stim_q.size() > 0 || exp_q.size() > 0) && cyc < 3000) begin
            @(posedge clk);
            #2;
            cyc++;
            if (!hold) begin
                if (stim_q.size() > 0 && int'($urandom_range(99)) < vprob) begin
                    valid_in = 1'b1;
                    data_in  = stim_q[0];
                end else begin
                    valid_in = 1'b0;
                    data_in  = 8'($urandom);
                end
            end
            case (rmode)
                0:       ready_out = 1'b1;
                1:       ready_out = ~ready_out;
                default: ready_out = 1'($urandom_range(1));
            endcase
            @(negedge clk);
            hold = valid_in && !ready_in;
            if (valid_in && ready_in) begin
                accept(stim_q.pop_front());
                acc++;
            end
        end
        check("run_timeout", 32'(cyc < 3000), 32'd1);
        @(posedge clk);
        #2;
        valid_in  = 1'b0;
        ready_out = 1'b1;
    endtask

    task automatic set_mode(input bit en);
        @(posedge clk);
        #2;
        enable_upsample = en;
        valid_in        = 1'b0;
        ready_out       = 1'b1;
        repeat (3) @(posedge clk);
        mdl_up = en;
    endtask

    task automatic push4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d);
        stim_q.push_back(a);
        stim_q.push_back(b);
        stim_q.push_back(c);
        stim_q.push_back(d);
    endtask

    initial begin
        reset_n         = 1'b0;
        enable_upsample = 1'b0;
        valid_in        = 1'b0;
        data_in         = 8'h00;
        ready_out       = 1'b1;
        #1;
        check("reset_valid_out", 32'(valid_out), 32'd0);
        check("reset_ready_in_hi", 32'(ready_in), 32'd1);
        ready_out = 1'b0;
        #1;
        check("reset_ready_in_lo", 32'(ready_in), 32'd0);
        ready_out = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;

        // Bypass is combinational: a stalled pixel is visible the same cycle.
        @(posedge clk);
        #2;
        valid_in  = 1'b1;
        data_in   = 8'h7F;
        ready_out = 1'b0;
        #1;
        check("byp_same_cycle_valid", 32'(valid_out), 32'd1);
        check("byp_same_cycle_data", 32'(data_out), 32'h7F);
        check("byp_same_cycle_ready", 32'(ready_in), 32'd0);
        @(posedge clk);
        #2;
        ready_out = 1'b1;
        @(negedge clk);
        if (valid_in && ready_in) accept(data_in);
        @(posedge clk);
        #2;
        valid_in = 1'b0;

        set_mode(1'b1);
        push4(8'd10, 8'd20, 8'd30, 8'd40);
        run(0, 100, 1000);
        push4(8'd10, 8'd20, 8'd30, 8'd40);
        run(1, 100, 1000);
        push4(8'h80, 8'h7F, 8'hFF, 8'h00);
        run(2, 70, 1000);
        for (int i = 0; i < 6 * int'(W); i++) stim_q.push_back(8'($urandom));
        run(2, 60, 1000);

        // Reset mid-row discards the partial row.
        push4(8'd11, 8'd22, 8'd33, 8'd44);
        run(0, 100, 2);
        reset_n  = 1'b0;
        mdl_up   = 1'b0;
        valid_in = 1'b0;
        #1;
        check("midrow_reset_valid_out", 32'(valid_out), 32'd0);
        exp_q.delete();
        row_buf.delete();
        stim_q.delete();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        set_mode(1'b1);
        push4(8'd1, 8'd2, 8'd3, 8'd4);
        run(0, 100, 1000);

        set_mode(1'b0);
        for (int i = 0; i < 20; i++) stim_q.push_back(8'($urandom));
        run(2, 70, 1000);

        // Dropping enable mid-row must not cut the row pair short.
        set_mode(1'b1);
        push4(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        run(0, 100, 2);
        enable_upsample = 1'b0;
        run(1, 100, 1000);
        set_mode(1'b0);
        for (int i = 0; i < 12; i++) stim_q.push_back(8'($urandom));
        run(2, 80, 1000);

        set_mode(1'b1);
        for (int i = 0; i < 3 * int'(W); i++) stim_q.push_back(8'($urandom));
        run(1, 80, 1000);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/upsample_unit.md
UPSAMPLE_UNIT -- requirements
Module: upsample_unit

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 56, meaning input row length in pixels (output row length = 2*IN_WIDTH).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port enable_upsample  input  1  1 = 2x nearest-neighbour upsample, 0 = bypass.
REQ-005 SHALL have port valid_in  input  1  upstream pixel valid.
REQ-006 SHALL have port data_in  input  8  upstream pixel, INT8.
REQ-007 SHALL have port ready_in  output  1  block accepts data_in this cycle.
REQ-008 SHALL have port valid_out  output  1  downstream pixel valid.
REQ-009 SHALL have port data_out  output  8  downstream pixel, INT8.
REQ-010 SHALL have port ready_out  input  1  downstream accepts data_out this cycle.

Function
REQ-011 SHALL transfer a pixel on either side only in a cycle where valid and ready are both 1; valid_out/data_out SHALL stay stable while valid_out=1 and ready_out=0.
REQ-012 SHALL hold a registered mode bit mode_q, loaded from enable_upsample every cycle the block is idle (state FILL, wr_col=0, rd_col=0, out_vld=0), and held otherwise; mode changes mid-frame SHALL take effect only at the next idle point.
REQ-013 With mode_q=0 (bypass), valid_out=valid_in, data_out=data_in and ready_in=ready_out, combinationally, with zero latency.
REQ-014 With mode_q=1, each input pixel SHALL be emitted twice horizontally, and each input row SHALL be emitted twice vertically (4 output pixels per input pixel).
REQ-015 SHALL hold an IN_WIDTH x 8 line buffer, counters wr_col and rd_col (width $clog2(IN_WIDTH)), a duplicate-phase bit dup, an output register out_vld/out_data, and a 2-state FSM: FILL, REPLAY.
REQ-016 FILL: ready_in = !out_vld || (ready_out && dup && rd_col != IN_WIDTH-1).
REQ-017 FILL, input handshake: out_data <= data_in, out_vld <= 1, dup <= 0, line_buf[wr_col] <= data_in, wr_col increments.
REQ-018 FILL: valid_out=out_vld, data_out=out_data; input-to-first-output latency is 1 cycle.
REQ-019 FILL, output handshake with dup=0: dup <= 1, out_data held.
REQ-020 FILL, output handshake with dup=1: rd_col increments; out_vld <= 0 unless a new input is accepted in the same cycle (REQ-017 takes priority).
REQ-021 FILL, output handshake with dup=1 and rd_col=IN_WIDTH-1: FSM -> REPLAY, rd_col <= 0, wr_col <= 0, out_vld <= 0, dup <= 0.
REQ-022 REPLAY: ready_in=0, valid_out=1, data_out=line_buf[rd_col] combinationally; full throughput, 1 pixel per cycle under ready_out=1.
REQ-023 REPLAY, output handshake: dup=0 -> dup <= 1; dup=1 -> dup <= 0, rd_col increments.
REQ-024 REPLAY, output handshake with dup=1 and rd_col=IN_WIDTH-1: FSM -> FILL, rd_col <= 0; block is idle the next cycle.
REQ-025 SHALL not modify pixel values; there is no arithmetic and no sign conversion.
REQ-026 SHALL keep no frame/row-height counter; rows alternate FILL/REPLAY indefinitely.

Reset
REQ-027 While reset_n=0 (asynchronous): FSM=FILL, wr_col=0, rd_col=0, dup=0, out_vld=0, out_data=0, mode_q=0.
REQ-028 Line buffer contents SHALL not be reset; no output may depend on unwritten entries.
REQ-029 Reset asserted mid-row SHALL discard the partial row; after release, the first accepted pixel starts a new row at column 0.
REQ-030 Outputs after reset release: valid_out=valid_in, ready_in=ready_out (bypass, mode_q=0) until mode_q loads 1 one cycle after enable_upsample=1 while idle.

Verification
REQ-031 IN_WIDTH=4, enable=1, ready_out=1, inputs 10,20,30,40 back-to-back -> data_out 10,10,20,20,30,30,40,40,10,10,20,20,30,30,40,40; ready_in=0 through all 8 REPLAY cycles.
REQ-032 Same stimulus, ready_out toggling 1/0 each cycle -> identical output sequence; data_out stable during every stall; no input accepted while out_vld=1 and dup=0.
REQ-033 Bypass: enable=0, valid_in=1 data 0x7F, ready_out=0 -> same-cycle valid_out=1, data_out=0x7F, ready_in=0.
REQ-034 Signed extremes 0x80, 0x7F, 0xFF, 0x00 -> emitted bit-exact, each 4 times in the upsample pattern.
REQ-035 reset_n pulsed low after 2 of 4 inputs -> valid_out=0 immediately; new row 1,2,3,4 -> output 1,1,2,2,3,3,4,4 twice.
REQ-036 enable_upsample dropped to 0 mid-row -> upsampling continues to REPLAY completion; bypass starts the cycle after idle.
